uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Receive-side control FSM for the UART. It synchronises the asynchronous serial line and detects and validates the start bit. It samples each of 8 data bits at mid-bit and drives the shift-enable and serial data inputs of the downstream 8-bit SIPO register, which shifts right with the new bit entering at bit 7, so data is LSB-first. It checks the stop bit and flags byte completion or a framing error, so the consumer knows when the SIPO output holds a valid byte.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; integer, minimum 4, even values only.
CNT_W, $clog2(CLKS_PER_BIT), width of the bit-timing counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
rx_en  input  1  receiver enable; when low, the FSM stays in IDLE and does not detect new frames.
rx_i  input  1  raw asynchronous serial line; idles high.
shift_en  output  1  one-cycle pulse telling the SIPO to shift in data_o.
data_o  output  1  sampled data bit; valid while shift_en is high.
rx_done  output  1  one-cycle pulse: stop bit valid, SIPO holds the complete byte.
frame_err  output  1  one-cycle pulse: stop bit sampled low.
busy  output  1  high in every state except IDLE.

Behaviour:
- All outputs and all state are registered. Reset is checked only on rising clk edges while rst=1.
- Reset values: shift_en=0, data_o=0, rx_done=0, frame_err=0, busy=0, state=IDLE, counter=0, bit_idx=0, both synchroniser flops=1.
- Synchroniser: rx_i passes through 2 flops to give rx_s. rx_s lags rx_i by 2 cycles. rx_s is the only signal the FSM samples.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: if rx_en=1 and rx_s=0, go to START with counter=0.
- START: count up. When counter reaches CLKS_PER_BIT/2-1:
  - rx_s=0: go to DATA, counter=0, bit_idx=0.
  - rx_s=1: glitch; return to IDLE with no output pulse.
- DATA: count 0..CLKS_PER_BIT-1. At the terminal count:
  - assert shift_en=1 for exactly 1 cycle, with data_o=rx_s in the same cycle;
  - counter=0 and bit_idx increments;
  - after the 8th pulse (bit_idx was 7), go to STOP.
- DATA summary: exactly 8 shift_en pulses per accepted frame, spaced exactly CLKS_PER_BIT cycles apart.
- STOP: count 0..CLKS_PER_BIT-1 and sample rx_s at the terminal count.
  - rx_s=1: rx_done=1 for 1 cycle, go to IDLE.
  - rx_s=0: frame_err=1 for 1 cycle, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s=1, then go to IDLE. This prevents a break condition (line held low) being decoded as a stream of 0x00 frames.
- rx_en deasserted mid-frame: the current frame completes normally. rx_en gates only the IDLE->START transition.
- rx_done and frame_err are mutually exclusive and never asserted in the same cycle as shift_en.
- A new start bit is accepted on the cycle after returning to IDLE, so back-to-back frames with a single stop bit are received without loss.
- Counter wrap: the counter resets to 0 on every state transition and at each DATA terminal count. It never exceeds CLKS_PER_BIT-1.
- Reset mid-frame: the next edge with rst=1 returns to IDLE with all outputs 0. No partial rx_done or shift_en is issued. The SIPO contents are not this block's responsibility.
- Latency: rx_done asserts at 2 (synchroniser) + CLKS_PER_BIT/2 + 8*CLKS_PER_BIT + CLKS_PER_BIT cycles after the falling edge of rx_i. With defaults this is 2+8+128+16 = 154 cycles.

Test Plan:
- Reset then idle line: hold rst=1 for 3 cycles, then release with rx_i=1 for 200 cycles -> all outputs stay 0, busy=0.
- Byte 0xA5 at CLKS_PER_BIT=16, rx_en=1, sent LSB-first (1,0,1,0,0,1,0,1) with a valid stop bit:
  - exactly 8 shift_en pulses 16 cycles apart, data_o sequence 1,0,1,0,0,1,0,1;
  - rx_done pulses once, 154 cycles after the start edge;
  - an attached SIPO reads 0xA5.
- Glitch rejection: drive rx_i low for 3 cycles, then high -> START aborts at mid-bit, no shift_en or rx_done, busy returns to 0.
- Framing error: send 0x3C with the stop bit low, then hold the line low for 64 cycles, then high:
  - frame_err pulses once, rx_done never asserts;
  - the FSM stays in WAIT_IDLE until the line rises;
  - no further shift_en pulses while the line is low.
- Back-to-back frames 0x00 then 0xFF with one stop bit each -> two rx_done pulses 160 cycles apart and 16 shift_en pulses total.
- Reset mid-frame: assert rst after the 4th shift_en of 0x55 -> the next cycle shows IDLE with all outputs 0. A following full 0x55 frame receives correctly.

Source files
------------

// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the UART receive controller and its line/SIPO side.
// The master is the controller; the slave drives the line and enable and consumes the bit stream.
interface uart_rx_ctrl_if;
    logic rx_en;
    logic rx_i;
    logic shift_en;
    logic data_o;
    logic rx_done;
    logic frame_err;
    logic busy;

    modport master (
        input  rx_en,
        input  rx_i,
        output shift_en,
        output data_o,
        output rx_done,
        output frame_err,
        output busy
    );

    modport slave (
        output rx_en,
        output rx_i,
        input  shift_en,
        input  data_o,
        input  rx_done,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive control: synchronises the line, validates the start bit, samples 8 bits at mid-bit
// into a downstream right-shifting SIPO, then checks the stop bit. All outputs are registered.
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic            clk,
    input  logic            rst,
    uart_rx_ctrl_if.master  bus
);

    localparam int SYNC_STAGES = 2;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic             shift_en_reg, shift_en_next;
    logic             data_reg, data_next;
    logic             done_reg, done_next;
    logic             ferr_reg, ferr_next;
    logic             busy_reg, busy_next;

    logic sync_reg [SYNC_STAGES];
    logic sync_src [SYNC_STAGES];
    logic rx_s;

    // Two-flop synchroniser; stages preset to the idle line level so reset never looks like a start bit.
    assign sync_src[0] = bus.rx_i;
    assign sync_src[1] = sync_reg[0];
    assign rx_s        = sync_reg[SYNC_STAGES-1];

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_reg[gi] <= 1'b1;
                end else begin
                    sync_reg[gi] <= sync_src[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            bit_idx_reg  <= '0;
            shift_en_reg <= 1'b0;
            data_reg     <= 1'b0;
            done_reg     <= 1'b0;
            ferr_reg     <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_idx_reg  <= bit_idx_next;
            shift_en_reg <= shift_en_next;
            data_reg     <= data_next;
            done_reg     <= done_next;
            ferr_reg     <= ferr_next;
            busy_reg     <= busy_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        bit_idx_next  = bit_idx_reg;
        shift_en_next = 1'b0;
        data_next     = data_reg;
        done_next     = 1'b0;
        ferr_next     = 1'b0;

        unique case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (bus.rx_en && !rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                // A start bit that is high again at mid-bit was only a glitch.
                if (cnt_reg == HALF_LAST) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = rx_s ? IDLE : DATA;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_reg == BIT_LAST) begin
                    shift_en_next = 1'b1;
                    data_next     = rx_s;
                    cnt_next      = '0;
                    bit_idx_next  = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = WAIT_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            WAIT_IDLE: begin
                // A held-low line (break) must rise before another frame can start.
                cnt_next = '0;
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    assign bus.shift_en  = shift_en_reg;
    assign bus.data_o    = data_reg;
    assign bus.rx_done   = done_reg;
    assign bus.frame_err = ferr_reg;
    assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed scenarios plus randomized frames, checked every cycle
// against a bit-timing model of the receiver and a scoreboard of expected bytes.
module tb_uart_rx_ctrl;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_ctrl_if bus_if ();

    uart_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int total = 0;
    int bad   = 0;
    int edge_no = 0;

    // Model: time since the start bit was seen determines every sample point.
    typedef enum {M_IDLE, M_FRAME, M_WAIT} mmode_t;
    mmode_t m_mode = M_IDLE;
    int     m_t    = 0;
    logic   m_d1   = 1'b1;
    logic   m_d2   = 1'b1;
    logic   e_shift = 1'b0, e_data = 1'b0, e_done = 1'b0, e_ferr = 1'b0, e_busy = 1'b0;

    // Observed statistics
    int   shift_cnt = 0, done_cnt = 0, ferr_cnt = 0;
    logic busy_seen = 1'b0;
    logic [7:0] sipo = 8'h00;
    int   shift_edges[$];
    int   done_edges[$];
    logic data_q[$];
    logic [7:0] bytes_q[$];
    logic [7:0] exp_q[$];
    logic sb_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    initial begin : model
        logic rs;
        int   n;
        forever begin
            @(posedge clk);
            edge_no++;
            e_shift = 1'b0;
            e_done  = 1'b0;
            e_ferr  = 1'b0;
            if (rst) begin
                m_mode = M_IDLE;
                m_d1   = 1'b1;
                m_d2   = 1'b1;
                e_data = 1'b0;
            end else begin
                rs   = m_d2;
                m_d2 = m_d1;
                m_d1 = bus_if.rx_i;
                case (m_mode)
                    M_IDLE: if (bus_if.rx_en && !rs) begin
                        m_mode = M_FRAME;
                        m_t    = 0;
                    end
                    M_FRAME: begin
                        m_t++;
                        if (m_t == HALF) begin
                            if (rs) m_mode = M_IDLE;
                        end else if (m_t > HALF && (m_t - HALF) % CPB == 0) begin
                            n = (m_t - HALF) / CPB;
                            if (n <= 8) begin
                                e_shift = 1'b1;
                                e_data  = rs;
                            end else if (rs) begin
                                e_done = 1'b1;
                                m_mode = M_IDLE;
                            end else begin
                                e_ferr = 1'b1;
                                m_mode = M_WAIT;
                            end
                        end
                    end
                    M_WAIT: if (rs) m_mode = M_IDLE;
                    default: m_mode = M_IDLE;
                endcase
            end
            e_busy = (m_mode != M_IDLE);
        end
    end

    initial begin : monitor
        logic [7:0] eb;
        forever begin
            @(negedge clk);
            if (edge_no > 0) begin
                chk("shift_en", 32'(bus_if.shift_en), 32'(e_shift));
                chk("rx_done", 32'(bus_if.rx_done), 32'(e_done));
                chk("frame_err", 32'(bus_if.frame_err), 32'(e_ferr));
                chk("busy", 32'(bus_if.busy), 32'(e_busy));
                if (e_shift) chk("data_o", 32'(bus_if.data_o), 32'(e_data));
            end
            if (bus_if.shift_en === 1'b1) begin
                shift_cnt++;
                sipo = {bus_if.data_o, sipo[7:1]};
                shift_edges.push_back(edge_no);
                data_q.push_back(bus_if.data_o);
            end
            if (bus_if.rx_done === 1'b1) begin
                done_cnt++;
                done_edges.push_back(edge_no);
                bytes_q.push_back(sipo);
                if (sb_on) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 32'(sipo), 32'hFFFF_FFFF);
                    end else begin
                        eb = exp_q.pop_front();
                        chk("sb_byte", 32'(sipo), 32'(eb));
                    end
                end
            end
            if (bus_if.frame_err === 1'b1) ferr_cnt++;
            if (bus_if.busy === 1'b1) busy_seen = 1'b1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clr_stats();
        shift_cnt = 0; done_cnt = 0; ferr_cnt = 0; busy_seen = 1'b0;
        shift_edges.delete(); done_edges.delete(); data_q.delete(); bytes_q.delete();
    endtask

    // Drives start, 8 data bits LSB-first and the stop bit; the stop level is left on the line.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic drop_en,
                              output int start_edge);
        bus_if.rx_i = 1'b0;
        start_edge  = edge_no + 1;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            bus_if.rx_i = b[i];
            if (drop_en && i == 2) bus_if.rx_en = 1'b0;
            tick(CPB);
        end
        bus_if.rx_i = stop_v;
        tick(CPB);
    endtask

    task automatic wait_done(input int target, input int budget);
        int c = 0;
        while (done_cnt < target && c < budget) begin
            tick(1);
            c++;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_shift_en"}, 32'(bus_if.shift_en), 0);
        chk({tag, "_data_o"}, 32'(bus_if.data_o), 0);
        chk({tag, "_rx_done"}, 32'(bus_if.rx_done), 0);
        chk({tag, "_frame_err"}, 32'(bus_if.frame_err), 0);
        chk({tag, "_busy"}, 32'(bus_if.busy), 0);
    endtask

    initial begin : stim
        int s;
        logic [7:0] b;
        logic stop_v, drop, hit;
        logic [7:0] assembled;

        bus_if.rx_i  = 1'b1;
        bus_if.rx_en = 1'b1;
        rst = 1'b1;
        tick(3);
        chk_all_zero("reset");
        rst = 1'b0;
        clr_stats();
        tick(200);
        chk("idle_shift_cnt", 32'(shift_cnt), 0);
        chk("idle_done_cnt", 32'(done_cnt), 0);
        chk("idle_busy_seen", 32'(busy_seen), 0);
        $display("txn idle: shifts=%0d done=%0d", shift_cnt, done_cnt);

        // 0xA5 frame
        clr_stats();
        send_frame(8'hA5, 1'b1, 1'b0, s);
        wait_done(1, 40);
        chk("a5_shift_cnt", 32'(shift_cnt), 8);
        chk("a5_done_cnt", 32'(done_cnt), 1);
        if (done_edges.size() > 0) chk("a5_latency", 32'(done_edges[0] - s), 154);
        if (bytes_q.size() > 0) chk("a5_sipo", 32'(bytes_q[0]), 32'hA5);
        assembled = 8'h00;
        for (int i = 0; i < 8 && i < data_q.size(); i++) assembled[i] = data_q[i];
        chk("a5_data_seq", 32'(assembled), 32'hA5);
        for (int i = 1; i < shift_edges.size(); i++)
            chk("a5_shift_gap", 32'(shift_edges[i] - shift_edges[i-1]), CPB);
        $display("txn 0xA5: shifts=%0d sipo=%02h", shift_cnt, sipo);
        tick(10);

        // glitch
        clr_stats();
        bus_if.rx_i = 1'b0;
        tick(3);
        bus_if.rx_i = 1'b1;
        tick(20);
        chk("glitch_entered_start", 32'(busy_seen), 1);
        chk("glitch_shift_cnt", 32'(shift_cnt), 0);
        chk("glitch_done_cnt", 32'(done_cnt), 0);
        chk("glitch_busy", 32'(bus_if.busy), 0);
        $display("txn glitch: shifts=%0d busy=%0b", shift_cnt, bus_if.busy);

        // framing error followed by a 64-cycle break
        clr_stats();
        send_frame(8'h3C, 1'b0, 1'b0, s);
        tick(64);
        chk("ferr_cnt", 32'(ferr_cnt), 1);
        chk("ferr_done_cnt", 32'(done_cnt), 0);
        chk("ferr_shift_cnt", 32'(shift_cnt), 8);
        chk("ferr_sipo", 32'(sipo), 32'h3C);
        chk("ferr_wait_busy", 32'(bus_if.busy), 1);
        bus_if.rx_i = 1'b1;
        tick(6);
        chk("ferr_idle_busy", 32'(bus_if.busy), 0);
        chk("ferr_shift_after", 32'(shift_cnt), 8);
        $display("txn 0x3C bad stop: frame_err=%0d done=%0d", ferr_cnt, done_cnt);
        tick(10);

        // back-to-back 0x00, 0xFF
        clr_stats();
        send_frame(8'h00, 1'b1, 1'b0, s);
        send_frame(8'hFF, 1'b1, 1'b0, s);
        wait_done(2, 40);
        chk("b2b_done_cnt", 32'(done_cnt), 2);
        chk("b2b_shift_cnt", 32'(shift_cnt), 16);
        if (done_edges.size() > 1) chk("b2b_gap", 32'(done_edges[1] - done_edges[0]), 160);
        if (bytes_q.size() > 1) begin
            chk("b2b_byte0", 32'(bytes_q[0]), 32'h00);
            chk("b2b_byte1", 32'(bytes_q[1]), 32'hFF);
        end
        $display("txn 0x00+0xFF: done=%0d shifts=%0d", done_cnt, shift_cnt);
        tick(10);

        // reset after the 4th bit of 0x55
        clr_stats();
        hit = 1'b0;
        b = 8'h55;
        bus_if.rx_i = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8 && !hit; i++) begin
            bus_if.rx_i = b[i];
            for (int c = 0; c < CPB && !hit; c++) begin
                tick(1);
                if (shift_cnt == 4) hit = 1'b1;
            end
        end
        chk("midrst_reached_4", 32'(hit), 1);
        rst = 1'b1;
        tick(1);
        chk_all_zero("midrst");
        bus_if.rx_i = 1'b1;
        rst = 1'b0;
        tick(20);
        clr_stats();
        send_frame(8'h55, 1'b1, 1'b0, s);
        wait_done(1, 40);
        chk("midrst_done_cnt", 32'(done_cnt), 1);
        if (bytes_q.size() > 0) chk("midrst_byte", 32'(bytes_q[0]), 32'h55);
        $display("txn 0x55 after reset: done=%0d sipo=%02h", done_cnt, sipo);

        // randomized frames against the model and byte scoreboard
        sb_on = 1'b1;
        for (int f = 0; f < 40; f++) begin
            bus_if.rx_i = 1'b1;
            bus_if.rx_en = ($urandom_range(0, 3) != 0);
            tick($urandom_range(1, 40));
            if ($urandom_range(0, 4) == 0) begin
                bus_if.rx_i = 1'b0;
                tick($urandom_range(1, 4));
                bus_if.rx_i = 1'b1;
                tick(20);
            end
            b      = 8'($urandom);
            stop_v = ($urandom_range(0, 5) != 0);
            drop   = bus_if.rx_en && ($urandom_range(0, 4) == 0);
            if (bus_if.rx_en && stop_v) exp_q.push_back(b);
            send_frame(b, stop_v, drop, s);
            if (!stop_v) begin
                tick($urandom_range(0, 30));
                bus_if.rx_i = 1'b1;
            end
            tick(4);
            $display("txn rand %0d: byte=%02h stop=%0b done_total=%0d", f, b, stop_v, done_cnt);
        end
        tick(20);
        chk("sb_drained", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
